muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EX stage of the pipelined MIPS core; implements MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- Operands arrive already sign- or zero-extended by the ID/EX datapath. The block runs a fixed-latency shift/add or restoring-divide loop.
- Raises a stall request to the hazard logic whenever the pipeline needs HI/LO or a new mul/div while the loop is running.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  issue a mul/div; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- a  in  DATA_W  rs operand (multiplicand / dividend)
- b  in  DATA_W  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI (MTHI)
- mtlo  in  1  write wdata to LO (MTLO)
- wdata  in  DATA_W  MTHI/MTLO data
- hilo_rd  in  1  EX-stage instruction reads HI/LO (MFHI/MFLO)
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- busy  out  1  loop in progress
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- stall_req  out  1  combinational: busy & (start | hilo_rd | mthi | mtlo)

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, iteration counter=0.
- Reset asserted mid-operation aborts the loop. HI/LO are cleared and the in-flight result is discarded.
- States:
  - IDLE: start=1 latches op, captures |a|, |b| (signed ops) or a, b (unsigned ops), records the result sign flags and clears counter → CALC.
  - CALC: one iteration per cycle. Multiply is a shift-add into a 2*DATA_W accumulator. Divide is restoring (shift remainder, trial subtract, set quotient bit). The counter counts 0..DATA_W-1; at DATA_W-1 → FIX.
  - FIX: apply sign correction. Multiply negates the 64-bit product if the operand signs differ. Divide negates the quotient if the signs differ and gives the remainder the sign of the dividend. Write hi/lo, done=1 → IDLE.
- Latency: start sampled at edge E0 → hi/lo valid and done=1 after edge E0+DATA_W+1 (33 for DATA_W=32). busy=1 from after E0 until that same edge.
- busy is registered: 1 in CALC and FIX, 0 in IDLE.
- MUL result: hi = product[63:32], lo = product[31:0].
- DIV result: lo = quotient, hi = remainder.
- Divide by zero is deterministic: hi=a, lo=all ones, for both signed and unsigned. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No exception.
- start while busy: ignored. Hazard logic holds the instruction via stall_req and it is re-presented after done.
- mthi/mtlo while busy: ignored, stall_req asserted.
- mthi/mtlo in IDLE: write on the next edge; hi and lo may be written in the same cycle.
- start together with mthi/mtlo in IDLE: start wins; the writes are dropped.
- done is never asserted for MTHI/MTLO writes.
- hi/lo hold their previous values throughout CALC; they change only at FIX, an MTHI/MTLO write, or reset.

Decomposition:
- Shared package holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU
  - state enum IDLE/CALC/FIX
  - DATA_W default
- One natural sub-module: muldiv_sign_fix. It is the combinational magnitude/conditional-negate helper, used at operand capture and in FIX.

Test Plan:
- MULTU a=FFFFFFFF b=FFFFFFFF → after 33 cycles hi=FFFFFFFE, lo=00000001; done high exactly 1 cycle; busy low the same cycle.
- MULT a=FFFFFFFD (-3), b=00000007 → hi=FFFFFFFF, lo=FFFFFFEB. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=FFFFFFF9 (-7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF → lo=80000000, hi=0.
- DIV/DIVU with b=0, a=12345678 → hi=12345678, lo=FFFFFFFF, latency 33.
- During CALC:
  - assert start (new operands), hilo_rd and mthi → stall_req=1 each cycle, result equals the first op, HI unchanged by mthi.
  - In IDLE, mthi wdata=AA55AA55 → hi=AA55AA55 next cycle, done=0.
- rst asserted on cycle 10 of CALC → next cycle state IDLE, busy=0, hi=lo=0, no done pulse. A following MULTU 3*4 gives lo=C, hi=0.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_seq_pkg
// Shared definitions for the iterative multiply/divide sequencer:
//   - operand/HI/LO width default
//   - mul/div opcode encodings as seen on the op port
//   - sequencer state encoding
//   - small opcode decode helpers
// ---------------------------------------------------------------------------
package muldiv_seq_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // op[1] selects divide, op[0] selects the unsigned variant.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
// Pipeline-side bundle of the multiply/divide sequencer.
//   start/op/a/b          : issue a MULT/MULTU/DIV/DIVU
//   mthi/mtlo/wdata       : direct HI/LO writes
//   hilo_rd               : EX-stage MFHI/MFLO present
//   hi/lo                 : architectural HI/LO
//   busy/done/stall_req   : status and hazard request
// master = pipeline side, slave = sequencer.
// ---------------------------------------------------------------------------
interface muldiv_seq_if
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              mthi;
  logic              mtlo;
  logic [DATA_W-1:0] wdata;
  logic              hilo_rd;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;
  logic              stall_req;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, hilo_rd,
    input  hi, lo, busy, done, stall_req
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, hilo_rd,
    output hi, lo, busy, done, stall_req
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// ---------------------------------------------------------------------------
// muldiv_sign_fix
// Combinational conditional two's-complement negate.
//   din  : value in
//   neg  : 1 = output -din, 0 = pass through
//   dout : result
// Used both to take operand magnitudes at capture and to restore result
// signs at the end of the loop.
// ---------------------------------------------------------------------------
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    if (neg) dout = ~din + W'(1);
  end

endmodule

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any loop, clears HI/LO)
//   bus  : muldiv_seq_if.slave (issue, MTHI/MTLO, HI/LO, busy/done/stall)
// One iteration per cycle for DATA_W cycles, then one sign-fix cycle.
// Signed ops run on magnitudes; signs are restored in FIX.
// ---------------------------------------------------------------------------
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic        clk,
  input logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_W);

  md_state_e           state;
  logic [CW-1:0]       cnt;
  logic                is_div;
  logic                neg_a;
  logic                neg_b;
  logic                b_zero;
  // Multiply: opb = multiplicand, acc = {partial product, multiplier}.
  // Divide:   opb = divisor,      acc = {remainder, dividend/quotient}.
  logic [DATA_W-1:0]   opb;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic                busy_q;
  logic                done_q;

  // Operand capture
  logic              cap_signed;
  logic              cap_neg_a;
  logic              cap_neg_b;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;

  always_comb begin
    cap_signed = op_is_signed(bus.op);
    cap_neg_a  = cap_signed & bus.a[DATA_W-1];
    cap_neg_b  = cap_signed & bus.b[DATA_W-1];
  end

  muldiv_sign_fix #(.W(DATA_W)) u_mag_a (
    .din  (bus.a),
    .neg  (cap_neg_a),
    .dout (a_mag)
  );

  muldiv_sign_fix #(.W(DATA_W)) u_mag_b (
    .din  (bus.b),
    .neg  (cap_neg_b),
    .dout (b_mag)
  );

  // One iteration step
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_trial;
  logic                div_ok;
  logic [DATA_W-1:0]   div_rem;
  logic [2*DATA_W-1:0] div_next;

  always_comb begin
    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} +
               {1'b0, (acc[0] ? opb : {DATA_W{1'b0}})};
    mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Restoring divide: remainder stays below the divisor, so the shifted
    // value fits in DATA_W+1 bits and the trial borrow is its MSB.
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_trial = div_shift - {1'b0, opb};
    div_ok    = ~div_trial[DATA_W];
    div_rem   = div_ok ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_next  = {div_rem, acc[DATA_W-2:0], div_ok};
  end

  // Result sign restoration
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic                prod_neg;
  logic                quo_neg;

  always_comb begin
    prod_neg = neg_a ^ neg_b;
    // A zero divisor yields an all-ones quotient from the loop itself; it
    // is left un-negated, and the remainder (|a|) regains a's sign, so
    // HI ends up equal to the original dividend.
    quo_neg  = (neg_a ^ neg_b) & ~b_zero;
  end

  muldiv_sign_fix #(.W(2*DATA_W)) u_fix_prod (
    .din  (acc),
    .neg  (prod_neg),
    .dout (prod_fix)
  );

  muldiv_sign_fix #(.W(DATA_W)) u_fix_quo (
    .din  (acc[DATA_W-1:0]),
    .neg  (quo_neg),
    .dout (quo_fix)
  );

  muldiv_sign_fix #(.W(DATA_W)) u_fix_rem (
    .din  (acc[2*DATA_W-1:DATA_W]),
    .neg  (neg_a),
    .dout (rem_fix)
  );

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
      opb    <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= op_is_div(bus.op);
            neg_a  <= cap_neg_a;
            neg_b  <= cap_neg_b;
            b_zero <= (bus.b == '0);
            if (op_is_div(bus.op)) begin
              opb <= b_mag;
              acc <= {{DATA_W{1'b0}}, a_mag};
            end else begin
              opb <= a_mag;
              acc <= {{DATA_W{1'b0}}, b_mag};
            end
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end

        CALC: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(DATA_W - 1)) state <= FIX;
        end

        FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*DATA_W-1:DATA_W];
            lo_q <= prod_fix[DATA_W-1:0];
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stall_req = busy_q & (bus.start | bus.hilo_rd | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  muldiv_seq_if #(.DATA_W(32)) bus ();

  muldiv_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  logic done_prev;
  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.done) begin
      chk("done_single_cycle", {31'b0, done_prev}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", bus.hi, e.hi);
        chk("result_lo", bus.lo, e.lo);
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", {31'b0, bus.busy}, 32'h0);
      end
    end
    done_prev = bus.done;
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    chk("stall_idle_start", {31'b0, bus.stall_req}, 32'h0);
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'h1, 32'h0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    cyc          = 0;
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.a        = '0;
    bus.b        = '0;
    bus.mthi     = 1'b0;
    bus.mtlo     = 1'b0;
    bus.wdata    = '0;
    bus.hilo_rd  = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_done", {31'b0, bus.done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    chk("busy_after_start", {31'b0, bus.busy}, 32'h1);
    wait_done();
    issue(MD_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB); wait_done();
    issue(MD_DIVU,  32'h00000007, 32'h00000002, 1'b1, 32'h00000001, 32'h00000003); wait_done();
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD); wait_done();
    issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000); wait_done();
    issue(MD_DIV,   32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'hFFFFFFFF); wait_done();
    issue(MD_DIVU,  32'h12345678, 32'h00000000, 1'b1, 32'h12345678, 32'hFFFFFFFF); wait_done();
    issue(MD_DIV,   32'hFFFFFFF9, 32'h00000000, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFF); wait_done();
    issue(MD_MULT,  32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000); wait_done();

    // Hazards during CALC: HI/LO currently 40000000/00000000.
    issue(MD_MULTU, 32'h00000003, 32'h00000005, 1'b1, 32'h00000000, 32'h0000000F);
    bus.wdata = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      bus.start   = (i == 0) || (i >= 4);
      bus.op      = MD_DIVU;
      bus.a       = 32'h00000064;
      bus.b       = 32'h00000007;
      bus.hilo_rd = (i == 1) || (i >= 4);
      bus.mthi    = (i == 2) || (i >= 4);
      bus.mtlo    = (i == 3) || (i >= 4);
      #1;
      chk("stall_in_calc", {31'b0, bus.stall_req}, 32'h1);
      @(negedge clk);
      chk("hi_held_in_calc", bus.hi, 32'h40000000);
      chk("lo_held_in_calc", bus.lo, 32'h00000000);
    end
    bus.start   = 1'b0;
    bus.hilo_rd = 1'b0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    wait_done();
    chk("busy_idle_after_hazard", {31'b0, bus.busy}, 32'h0);

    bus.hilo_rd = 1'b1;
    #1;
    chk("stall_idle_hilo_rd", {31'b0, bus.stall_req}, 32'h0);
    bus.hilo_rd = 1'b0;

    // MTHI in IDLE
    bus.mthi  = 1'b1;
    bus.wdata = 32'hAA55AA55;
    @(negedge clk);
    bus.mthi = 1'b0;
    chk("mthi_hi", bus.hi, 32'hAA55AA55);
    chk("mthi_lo_kept", bus.lo, 32'h0000000F);
    chk("mthi_no_done", {31'b0, bus.done}, 32'h0);

    // MTHI + MTLO together
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h13579BDF;
    @(negedge clk);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthilo_hi", bus.hi, 32'h13579BDF);
    chk("mthilo_lo", bus.lo, 32'h13579BDF);

    // start wins over MTHI/MTLO in IDLE
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hFFFF0000;
    issue(MD_MULTU, 32'h00000002, 32'h00000003, 1'b1, 32'h00000000, 32'h00000006);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("start_wins_hi", bus.hi, 32'h13579BDF);
    chk("start_wins_lo", bus.lo, 32'h13579BDF);
    wait_done();

    // Reset in the middle of CALC
    issue(MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_hi", bus.hi, 32'h0);
    chk("abort_lo", bus.lo, 32'h0);
    repeat (40) @(negedge clk);
    issue(MD_MULTU, 32'h00000003, 32'h00000004, 1'b1, 32'h00000000, 32'h0000000C);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
